// File: rtl/aemb2_xslsif_if.sv
// XSL accelerator bus bundle between the AEMB2 core (master) and the
// FSL responder (slave). The channel-select width tracks AEMB_XWB.
interface aemb2_xslsif_if #(
  parameter int AEMB_XWB = 3
) ();
  logic [AEMB_XWB-3:0] xwb_adr_i;
  logic [31:0]         xwb_dat_i;
  logic [3:0]          xwb_sel_i;
  logic                xwb_tag_i;
  logic                xwb_wre_i;
  logic                xwb_stb_i;
  logic                xwb_cyc_i;
  logic [31:0]         xwb_dat_o;
  logic                xwb_tag_o;
  logic                xwb_ack_o;

  modport master (
    output xwb_adr_i, xwb_dat_i, xwb_sel_i, xwb_tag_i, xwb_wre_i, xwb_stb_i, xwb_cyc_i,
    input  xwb_dat_o, xwb_tag_o, xwb_ack_o
  );

  modport slave (
    input  xwb_adr_i, xwb_dat_i, xwb_sel_i, xwb_tag_i, xwb_wre_i, xwb_stb_i, xwb_cyc_i,
    output xwb_dat_o, xwb_tag_o, xwb_ack_o
  );
endinterface

// File: rtl/aemb2_xslsif.sv
// AEMB2 XSL responder: per-channel outbound (PUT) and inbound (GET) FIFOs.
// Blocking FSL behaviour is produced by withholding ack until the selected
// FIFO has room (PUT) or data (GET). Full/empty are judged on registered
// counts only, so a same-cycle accelerator transfer never bypasses.
module aemb2_xslsif #(
  parameter int AEMB_XWB = 3,
  parameter int AEMB_DLG = 2,
  localparam int NCH = 2 ** (AEMB_XWB - 2)
) (
  input  logic              gclk,
  input  logic              grst,
  aemb2_xslsif_if.slave     xwb,
  output logic [32*NCH-1:0] acc_put_dat_o,
  output logic [NCH-1:0]    acc_put_tag_o,
  output logic [NCH-1:0]    acc_put_vld_o,
  input  logic [NCH-1:0]    acc_put_rdy_i,
  input  logic [32*NCH-1:0] acc_get_dat_i,
  input  logic [NCH-1:0]    acc_get_tag_i,
  input  logic [NCH-1:0]    acc_get_vld_i,
  output logic [NCH-1:0]    acc_get_rdy_o
);
  localparam int CW    = AEMB_XWB - 2;
  localparam int PW    = AEMB_DLG;
  localparam int DEPTH = 2 ** AEMB_DLG;

  typedef logic [32:0] word_t;  // {tag, data}

  word_t       put_mem_q [NCH][DEPTH];
  word_t       put_mem_d [NCH][DEPTH];
  word_t       get_mem_q [NCH][DEPTH];
  word_t       get_mem_d [NCH][DEPTH];
  logic [PW-1:0] put_wp_q [NCH], put_wp_d [NCH], put_rp_q [NCH], put_rp_d [NCH];
  logic [PW-1:0] get_wp_q [NCH], get_wp_d [NCH], get_rp_q [NCH], get_rp_d [NCH];
  logic [PW:0]   put_cnt_q [NCH], put_cnt_d [NCH];
  logic [PW:0]   get_cnt_q [NCH], get_cnt_d [NCH];
  logic          ack_q, ack_d;
  logic [31:0]   dat_q, dat_d;
  logic          tag_q, tag_d;

  logic [CW-1:0]  chn;
  logic           req;
  logic [NCH-1:0] put_push, put_pop, get_push, get_pop;
  logic           unused_sel;

  // Byte selects carry no meaning on the FSL path; transfers are whole words.
  assign unused_sel = ^xwb.xwb_sel_i;
  assign chn        = xwb.xwb_adr_i;

  // Per-channel push/pop strobes from the registered FIFO occupancy.
  always_comb begin
    req      = xwb.xwb_stb_i & xwb.xwb_cyc_i & ~ack_q;
    put_push = '0;
    put_pop  = '0;
    get_push = '0;
    get_pop  = '0;
    for (int c = 0; c < NCH; c++) begin
      put_push[c] = req & xwb.xwb_wre_i & (chn == CW'(c)) &
                    (put_cnt_q[c] != (PW+1)'(DEPTH));
      put_pop[c]  = (put_cnt_q[c] != '0) & acc_put_rdy_i[c];
      get_push[c] = acc_get_vld_i[c] & (get_cnt_q[c] != (PW+1)'(DEPTH));
      get_pop[c]  = req & ~xwb.xwb_wre_i & (chn == CW'(c)) &
                    (get_cnt_q[c] != '0);
    end
  end

  // Next-state for FIFO storage, pointers, counts and the bus response.
  always_comb begin
    put_mem_d = put_mem_q;
    get_mem_d = get_mem_q;
    put_wp_d  = put_wp_q;
    put_rp_d  = put_rp_q;
    get_wp_d  = get_wp_q;
    get_rp_d  = get_rp_q;
    put_cnt_d = put_cnt_q;
    get_cnt_d = get_cnt_q;
    dat_d     = dat_q;
    tag_d     = tag_q;
    ack_d     = (|put_push) | (|get_pop);
    for (int c = 0; c < NCH; c++) begin
      if (put_push[c]) begin
        put_mem_d[c][put_wp_q[c]] = {xwb.xwb_tag_i, xwb.xwb_dat_i};
        put_wp_d[c] = put_wp_q[c] + PW'(1);
      end
      if (put_pop[c]) put_rp_d[c] = put_rp_q[c] + PW'(1);
      case ({put_push[c], put_pop[c]})
        2'b10:   put_cnt_d[c] = put_cnt_q[c] + (PW+1)'(1);
        2'b01:   put_cnt_d[c] = put_cnt_q[c] - (PW+1)'(1);
        default: put_cnt_d[c] = put_cnt_q[c];
      endcase

      if (get_push[c]) begin
        get_mem_d[c][get_wp_q[c]] = {acc_get_tag_i[c], acc_get_dat_i[32*c +: 32]};
        get_wp_d[c] = get_wp_q[c] + PW'(1);
      end
      if (get_pop[c]) begin
        get_rp_d[c] = get_rp_q[c] + PW'(1);
        dat_d       = get_mem_q[c][get_rp_q[c]][31:0];
        tag_d       = get_mem_q[c][get_rp_q[c]][32];
      end
      case ({get_push[c], get_pop[c]})
        2'b10:   get_cnt_d[c] = get_cnt_q[c] + (PW+1)'(1);
        2'b01:   get_cnt_d[c] = get_cnt_q[c] - (PW+1)'(1);
        default: get_cnt_d[c] = get_cnt_q[c];
      endcase
    end
  end

  // Control state: reset empties every FIFO and abandons any pending ack.
  always_ff @(posedge gclk) begin
    if (grst) begin
      for (int c = 0; c < NCH; c++) begin
        put_wp_q[c]  <= '0;
        put_rp_q[c]  <= '0;
        get_wp_q[c]  <= '0;
        get_rp_q[c]  <= '0;
        put_cnt_q[c] <= '0;
        get_cnt_q[c] <= '0;
      end
      ack_q <= 1'b0;
      dat_q <= '0;
      tag_q <= 1'b0;
    end else begin
      put_wp_q  <= put_wp_d;
      put_rp_q  <= put_rp_d;
      get_wp_q  <= get_wp_d;
      get_rp_q  <= get_rp_d;
      put_cnt_q <= put_cnt_d;
      get_cnt_q <= get_cnt_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      tag_q     <= tag_d;
    end
  end

  // FIFO storage: contents are meaningless while the count is zero.
  always_ff @(posedge gclk) begin
    put_mem_q <= put_mem_d;
    get_mem_q <= get_mem_d;
  end

  // Accelerator-side views: outbound head falls through, inbound ready = not full.
  always_comb begin
    acc_put_dat_o = '0;
    acc_put_tag_o = '0;
    acc_put_vld_o = '0;
    acc_get_rdy_o = '0;
    for (int c = 0; c < NCH; c++) begin
      acc_put_dat_o[32*c +: 32] = put_mem_q[c][put_rp_q[c]][31:0];
      acc_put_tag_o[c]          = put_mem_q[c][put_rp_q[c]][32];
      acc_put_vld_o[c]          = (put_cnt_q[c] != '0);
      acc_get_rdy_o[c]          = (get_cnt_q[c] != (PW+1)'(DEPTH));
    end
  end

  assign xwb.xwb_ack_o = ack_q;
  assign xwb.xwb_dat_o = dat_q;
  assign xwb.xwb_tag_o = tag_q;
endmodule

// File: doc/aemb2_xslsif.md
Name: aemb2_xslsif

Overview:
- Responder (slave) end of the AEMB2 XSL accelerator bus.
- Terminates the core's Wishbone-style GET/PUT transactions on 2^(AEMB_XWB-2) FSL channels.
- Each channel has one outbound FIFO (core PUT → accelerator) and one inbound FIFO (accelerator GET → core).
- Blocking FSL semantics come from withholding xwb_ack_o until FIFO space or data is available.
- Sits between the core's XSL master port and user accelerator streams.

Parameters:
- AEMB_XWB, 3, XSL address width; channel index = xwb_adr_i[AEMB_XWB-1:2]; NCH = 2^(AEMB_XWB-2) channels (default 2).
- AEMB_DLG, 2, log2 FIFO depth; each FIFO holds 2^AEMB_DLG entries of 33 bits ({tag,data}).

Ports:
- gclk  in  1  clock.
- grst  in  1  reset; synchronous, active-high.
- xwb_adr_i  in  AEMB_XWB-2  channel select.
- xwb_dat_i  in  32  PUT data.
- xwb_sel_i  in  4  byte select; ignored, always full word.
- xwb_tag_i  in  1  control bit (cPUT/cGET).
- xwb_wre_i  in  1  1=PUT, 0=GET.
- xwb_stb_i  in  1  strobe.
- xwb_cyc_i  in  1  cycle.
- xwb_dat_o  out  32  GET data.
- xwb_tag_o  out  1  control bit of the popped GET word.
- xwb_ack_o  out  1  transfer acknowledge.
- acc_put_dat_o  out  32*NCH  outbound FIFO head data; channel n at bits [32n+31:32n].
- acc_put_tag_o  out  NCH  outbound head control bit.
- acc_put_vld_o  out  NCH  outbound FIFO not empty.
- acc_put_rdy_i  in  NCH  accelerator consumes head.
- acc_get_dat_i  in  32*NCH  inbound data.
- acc_get_tag_i  in  NCH  inbound control bit.
- acc_get_vld_i  in  NCH  inbound word valid.
- acc_get_rdy_o  out  NCH  inbound FIFO not full.

Behaviour:
- Reset values:
  - xwb_ack_o=0, xwb_dat_o=0, xwb_tag_o=0.
  - All FIFOs empty: pointers and counts 0.
  - acc_put_vld_o=0, acc_get_rdy_o=all 1.
  - Reset mid-transaction abandons it and discards all FIFO contents; no ack is issued.
- Request: req = xwb_stb_i & xwb_cyc_i & !xwb_ack_o. Sampled only while ack is low, so every ack is followed by at least one ack-low cycle and one transaction is never acknowledged twice. Back-to-back requests are acknowledged at most every 2nd cycle.
- PUT (xwb_wre_i=1):
  - If req and the selected outbound FIFO is not full at the clock edge: push {xwb_tag_i,xwb_dat_i}, and xwb_ack_o=1 for exactly one cycle starting the next cycle (1-cycle latency).
  - If full: no push, ack held low; retried every cycle while stb stays high (blocking PUT).
- GET (xwb_wre_i=0):
  - If req and the selected inbound FIFO is not empty: pop the head, and next cycle xwb_dat_o/xwb_tag_o = popped word with xwb_ack_o=1 for one cycle.
  - If empty: ack held low (blocking GET).
  - xwb_dat_o/xwb_tag_o hold their value until the next GET completes; PUT does not change them.
- Tag: stored and returned verbatim; no mismatch check in this block. The core compares the returned tag.
- Accelerator side:
  - Outbound FIFO is first-word-fall-through: acc_put_vld_o = !empty; pop on vld&rdy.
  - Inbound FIFO pushes on acc_get_vld_i & acc_get_rdy_o, with acc_get_rdy_o = !full.
  - All channels are independent and may transfer in the same cycle.
- Full/empty are evaluated at the start of the cycle; there is no same-cycle bypass.
  - Full outbound FIFO with a simultaneous accelerator pop and bus PUT: pop occurs, push is refused this cycle, and PUT is acknowledged one cycle later than otherwise.
  - Empty inbound FIFO with a simultaneous accelerator push and bus GET: GET waits one cycle.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- Pointers are AEMB_DLG bits and wrap modulo depth. The count is AEMB_DLG+1 bits: full when count == 2^AEMB_DLG, empty when count == 0.
- If stb drops before ack, the request is withdrawn and no FIFO state changes.

Test Plan:
- PUT 0xDEADBEEF tag=1 on ch1 → ack high in the following cycle only; acc_put_vld_o[1]=1, acc_put_dat_o[63:32]=0xDEADBEEF, acc_put_tag_o[1]=1; ch0 untouched.
- Hold acc_put_rdy_i[0]=0 and PUT 5 words on ch0 (depth 4) → first 4 acked on alternate cycles, 5th ack withheld. Raise rdy for 1 cycle → 5th acked 2 cycles later; accelerator drains in order.
- GET ch0 with inbound empty → no ack for 10 cycles. Accelerator pushes 0x12345678 tag=0 → ack arrives 2 cycles after the push, with xwb_dat_o=0x12345678, xwb_tag_o=0.
- Accelerator fills ch1 inbound (4 words) → acc_get_rdy_o[1]=0. One core GET → rdy returns to 1 the next cycle. Data order is preserved across pointer wrap over 10 words.
- Assert grst while a PUT is blocked and FIFOs are non-empty → next cycle ack=0, all acc_put_vld_o=0, acc_get_rdy_o=all 1, xwb_dat_o=0.
- Hold stb continuously through two consecutive GETs → exactly two ack pulses separated by an ack-low cycle; no double pop.
